parking_lot_ctrl: RTL and testbench
===================================

Name: parking_lot_ctrl

Overview:
Parametrised parking-lot controller, successor to the fixed nine-slot slot manager. It issues unique non-zero tokens from an LFSR at entry and keeps a per-slot token table. It validates tokens at exit and drives the entry and exit gates through independent FSMs with passage timeouts. It sits between the debounced button/sensor front end and the slot-count display logic.

Parameters:
CAPACITY, 9, number of slots; legal range 1 to 2**TOKEN_W-2.
TOKEN_W, 4, token width; legal range 4..8, selects the LFSR tap entry in the package.
GATE_TIMEOUT, 10, clk_1Hz cycles a gate may stay open without a passage before it auto-closes.
LFSR_SEED, 1, LFSR reset value; must be non-zero.

Ports:
clk_1Hz  in  1  system tick.
reset  in  1  asynchronous, active-high.
entry_req  in  1  one-cycle pulse from an external debouncer.
entry_sensor  in  1  high while a car is under the entry gate.
exit_req  in  1  one-cycle pulse from an external debouncer.
exit_sensor  in  1  high while a car is under the exit gate.
token_in  in  TOKEN_W  token presented at exit; sampled on exit_req.
occupied_count  out  CNT_W  occupied slots; CNT_W = $clog2(CAPACITY+1).
remaining_count  out  CNT_W  equals CAPACITY - occupied_count.
full  out  1  occupied_count == CAPACITY.
empty  out  1  occupied_count == 0.
entry_gate_open  out  1  entry gate command.
exit_gate_open  out  1  exit gate command.
issued_token  out  TOKEN_W  token for the car at entry; 0 when none.
exit_reject  out  1  one-cycle pulse on an invalid exit token.

Behaviour:
- Clock and reset: reset asynchronous, active-high; clock clk_1Hz.
- Reset values: table all 0, counts 0, remaining_count = CAPACITY, empty = 1, full = 0, gates closed, issued_token 0, exit_reject 0, LFSR = LFSR_SEED, both FSMs idle, sensor-history regs 0.
- Reset mid-operation (gate open, search in progress) aborts everything; no pending token survives.
- Token value 0 is reserved for "unused" and is never issued or accepted.
- LFSR: maximal-length Fibonacci, advances every cycle, never reaches 0.
- Entry FSM, E_IDLE: on entry_req with full = 0, go to E_SEARCH. entry_req while full is ignored.
- Entry FSM, E_SEARCH (one cycle per attempt): compare the LFSR value against all table entries.
  - On a miss, latch it into issued_token, set entry_gate_open = 1 on the next edge, go to E_OPEN.
  - On a hit, retry next cycle. Termination is guaranteed because CAPACITY < 2**TOKEN_W-1.
- Entry FSM, E_OPEN: a falling edge of entry_sensor commits.
  - Write issued_token to the lowest-index zero slot, increment occupied_count, close the gate, clear issued_token, return to E_IDLE.
  - Timeout (GATE_TIMEOUT cycles, no falling edge): close the gate, discard the token, no count change.
- Exit FSM, X_IDLE: on exit_req, a combinational match of token_in (non-zero) against the table.
  - Hit: latch the slot index, open exit_gate_open on the next edge, go to X_OPEN.
  - Miss or zero token: pulse exit_reject for 1 cycle, stay in X_IDLE.
- Exit FSM, X_OPEN: the slot stays occupied until passage.
  - Falling edge of exit_sensor: clear the slot, decrement the count, close the gate.
  - Timeout: close the gate, slot kept.
  - exit_req while in X_OPEN is ignored.
- Simultaneous entry commit and exit commit: both table writes happen (distinct slots by construction); occupied_count unchanged.
- The count never wraps: it increments only when full = 0 at search time and decrements only on a matched slot.
- full, empty and remaining_count are combinational from occupied_count.

Optional Feature:
PARKING_FEE_EN.
- Defined: adds parameter FEE_W (default 8) and output fee_out [FEE_W].
  - Each slot has a saturating tick counter, cleared on the entry commit and incremented every cycle while occupied.
  - On an exit match, fee_out loads that slot's counter and holds until the next match.
  - fee_out resets to 0.
- Undefined: no counters, no fee_out port.

Decomposition:
Shared package parking_pkg holds:
- entry and exit FSM state enums;
- the LFSR tap-mask table indexed by TOKEN_W (4..8);
- the TOKEN_NONE = 0 constant.
One sub-module, parking_token_lfsr (TOKEN_W, LFSR_SEED, reset, clk_1Hz, value out). Table search is left inline.

Test Plan:
- Reset, then entry_req and a sensor pulse 1→0 → entry_gate_open rises 2 cycles after entry_req, occupied_count = 1, remaining_count = 8, table holds the issued non-zero token.
- Fill 9 cars, then entry_req → full = 1, gate stays closed; exit with a stored token plus sensor pulse → occupied_count = 8, full = 0.
- exit_req with token_in = 0 and with an unissued value → exit_reject pulses 1 cycle each, exit gate closed, count unchanged.
- Entry gate opened, no sensor activity for 10 cycles → gate closes, count unchanged, token not stored; exit timeout → slot retained, token still valid.
- Entry commit and exit commit on the same edge with count 5 → count stays 5, one slot written, another cleared.
- Seed a table collision (preload via entries until the LFSR value matches) → E_SEARCH retries and issues a distinct token; PARKING_FEE_EN: car parked 20 cycles → fee_out = 20.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot controller: FSM state enums,
// the reserved "unused" token value and the LFSR feedback-tap table.
package parking_pkg;

    typedef enum logic [1:0] {
        E_IDLE,
        E_SEARCH,
        E_OPEN
    } entry_state_t;

    typedef enum logic {
        X_IDLE,
        X_OPEN
    } exit_state_t;

    localparam int TOKEN_NONE = 0;

    // Maximal-length tap masks for a left-shifting Fibonacci LFSR, indexed by width.
    localparam logic [7:0] LFSR_TAPS [4:8] = '{8'h0C, 8'h14, 8'h30, 8'h60, 8'hB8};

endpackage

// File: rtl/parking_token_lfsr.sv
// Free-running maximal-length Fibonacci LFSR used as the token source;
// it never reaches zero as long as LFSR_SEED is non-zero.
module parking_token_lfsr
    import parking_pkg::*;
#(
    parameter int TOKEN_W   = 4,
    parameter int LFSR_SEED = 1
) (
    input  logic               clk_1Hz,
    input  logic               reset,
    output logic [TOKEN_W-1:0] value
);

    localparam logic [7:0]         TAP_ROW = LFSR_TAPS[TOKEN_W];
    localparam logic [TOKEN_W-1:0] TAPS    = TAP_ROW[TOKEN_W-1:0];

    logic feedback;

    assign feedback = ^(value & TAPS);

    always_ff @(posedge clk_1Hz or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) value <= TOKEN_W'(LFSR_SEED);
        else       value <= {value[TOKEN_W-2:0], feedback};
    end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: LFSR token issue, per-slot token table, entry/exit gate FSMs.
// Define PARKING_FEE_EN to add per-slot parking-time counters and the fee_out port.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 9,
    parameter int TOKEN_W      = 4,
    parameter int GATE_TIMEOUT = 10,
    parameter int LFSR_SEED    = 1,
`ifdef PARKING_FEE_EN
    parameter int FEE_W        = 8,
`endif
    localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic               clk_1Hz,
    input  logic               reset,
    input  logic               entry_req,
    input  logic               entry_sensor,
    input  logic               exit_req,
    input  logic               exit_sensor,
    input  logic [TOKEN_W-1:0] token_in,
    output logic [CNT_W-1:0]   occupied_count,
    output logic [CNT_W-1:0]   remaining_count,
    output logic               full,
    output logic               empty,
    output logic               entry_gate_open,
    output logic               exit_gate_open,
    output logic [TOKEN_W-1:0] issued_token,
    output logic               exit_reject
`ifdef PARKING_FEE_EN
    ,
    output logic [FEE_W-1:0]   fee_out
`endif
);

    localparam int IDX_W = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
    localparam int TMR_W = $clog2(GATE_TIMEOUT + 1);
    localparam logic [TOKEN_W-1:0] NONE     = TOKEN_W'(TOKEN_NONE);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);

    logic [TOKEN_W-1:0] table_q [CAPACITY];
    logic [TOKEN_W-1:0] lfsr_value;
    logic [TOKEN_W-1:0] issued_d;
    entry_state_t       e_state, e_state_d;
    exit_state_t        x_state, x_state_d;
    logic [TMR_W-1:0]   e_timer, x_timer;
    logic [IDX_W-1:0]   x_slot_q, token_idx, free_idx;
    logic               entry_sensor_q, exit_sensor_q;
    logic               e_fall, x_fall;
    logic               lfsr_hit, token_hit, free_found;
    logic               entry_commit, exit_commit, x_match, exit_reject_d;

    parking_token_lfsr #(
        .TOKEN_W   (TOKEN_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .value   (lfsr_value)
    );

    assign e_fall          = entry_sensor_q & ~entry_sensor;
    assign x_fall          = exit_sensor_q & ~exit_sensor;
    assign remaining_count = CNT_W'(CAPACITY) - occupied_count;
    assign full            = (occupied_count == CNT_W'(CAPACITY));
    assign empty           = (occupied_count == '0);
    assign entry_gate_open = (e_state == E_OPEN);
    assign exit_gate_open  = (x_state == X_OPEN);

    // Table search: LFSR collision, exit-token match and lowest free slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        lfsr_hit   = 1'b0;
        token_hit  = 1'b0;
        free_found = 1'b0;
        token_idx  = '0;
        free_idx   = '0;
        for (int i = 0; i < CAPACITY; i++) begin
            if (table_q[i] == lfsr_value) lfsr_hit = 1'b1;
            if (!token_hit && token_in != NONE && table_q[i] == token_in) begin
                token_hit = 1'b1;
                token_idx = IDX_W'(i);
            end
            if (!free_found && table_q[i] == NONE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        e_state_d    = e_state;
        issued_d     = issued_token;
        entry_commit = 1'b0;
        unique case (e_state)
            E_IDLE:   if (entry_req && !full) e_state_d = E_SEARCH;
            E_SEARCH: if (!lfsr_hit) begin
                issued_d  = lfsr_value;
                e_state_d = E_OPEN;
            end
            E_OPEN: begin
                if (e_fall && free_found) begin
                    entry_commit = 1'b1;
                    issued_d     = NONE;
                    e_state_d    = E_IDLE;
                end else if (e_timer == TMR_LAST) begin
                    issued_d  = NONE;
                    e_state_d = E_IDLE;
                end
            end
            default:  e_state_d = E_IDLE;
        endcase
    end

    always_comb begin
        x_state_d     = x_state;
        x_match       = 1'b0;
        exit_commit   = 1'b0;
        exit_reject_d = 1'b0;
        unique case (x_state)
            X_IDLE: if (exit_req) begin
                if (token_hit) begin
                    x_match   = 1'b1;
                    x_state_d = X_OPEN;
                end else begin
                    exit_reject_d = 1'b1;
                end
            end
            X_OPEN: begin
                if (x_fall) begin
                    exit_commit = 1'b1;
                    x_state_d   = X_IDLE;
                end else if (x_timer == TMR_LAST) begin
                    x_state_d = X_IDLE;
                end
            end
            default: x_state_d = X_IDLE;
        endcase
    end

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            e_state        <= E_IDLE;
            x_state        <= X_IDLE;
            e_timer        <= '0;
            x_timer        <= '0;
            x_slot_q       <= '0;
            issued_token   <= NONE;
            exit_reject    <= 1'b0;
            entry_sensor_q <= 1'b0;
            exit_sensor_q  <= 1'b0;
            occupied_count <= '0;
        end else begin
            e_state        <= e_state_d;
            x_state        <= x_state_d;
            e_timer        <= (e_state == E_OPEN) ? e_timer + 1'b1 : '0;
            x_timer        <= (x_state == X_OPEN) ? x_timer + 1'b1 : '0;
            issued_token   <= issued_d;
            exit_reject    <= exit_reject_d;
            entry_sensor_q <= entry_sensor;
            exit_sensor_q  <= exit_sensor;
            if (x_match) x_slot_q <= token_idx;
            if (entry_commit && !exit_commit)      occupied_count <= occupied_count + 1'b1;
            else if (exit_commit && !entry_commit) occupied_count <= occupied_count - 1'b1;
        end
    end

    // Entry and exit commits never target the same slot: the exiting slot is non-zero.
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            // NOTE: the table is cleared on reset because zero marks a free slot; no token may survive.
            for (int i = 0; i < CAPACITY; i++) table_q[i] <= NONE;
        end else begin
            if (exit_commit)  table_q[x_slot_q] <= NONE;
            if (entry_commit) table_q[free_idx] <= issued_token;
        end
    end

`ifdef PARKING_FEE_EN
    logic [FEE_W-1:0] fee_cnt [CAPACITY];

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CAPACITY; i++) fee_cnt[i] <= '0;
            fee_out <= '0;
        end else begin
            for (int i = 0; i < CAPACITY; i++) begin
                if (entry_commit && free_idx == IDX_W'(i))      fee_cnt[i] <= '0;
                else if (table_q[i] != NONE && fee_cnt[i] != '1) fee_cnt[i] <= fee_cnt[i] + 1'b1;
            end
            if (x_match) fee_out <= fee_cnt[token_idx];
        end
    end
`endif

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Self-checking bench for parking_lot_ctrl: directed stimulus, an event-level
// reference model compared every cycle, plus hand-computed literal expectations.
module tb_parking_lot_ctrl;

    localparam int CAPACITY     = 9;
    localparam int TOKEN_W      = 4;
    localparam int GATE_TIMEOUT = 10;
    localparam int CNT_W        = 4;

    logic               clk_1Hz = 1'b0;
    logic               reset = 1'b1;
    logic               entry_req = 1'b0, entry_sensor = 1'b0;
    logic               exit_req = 1'b0, exit_sensor = 1'b0;
    logic [TOKEN_W-1:0] token_in = '0;
    logic [CNT_W-1:0]   occupied_count, remaining_count;
    logic               full, empty, entry_gate_open, exit_gate_open, exit_reject;
    logic [TOKEN_W-1:0] issued_token;
`ifdef PARKING_FEE_EN
    logic [7:0]         fee_out;
`endif

    parking_lot_ctrl #(
        .CAPACITY     (CAPACITY),
        .TOKEN_W      (TOKEN_W),
        .GATE_TIMEOUT (GATE_TIMEOUT),
        .LFSR_SEED    (1)
    ) dut (
        .clk_1Hz         (clk_1Hz),
        .reset           (reset),
        .entry_req       (entry_req),
        .entry_sensor    (entry_sensor),
        .exit_req        (exit_req),
        .exit_sensor     (exit_sensor),
        .token_in        (token_in),
        .occupied_count  (occupied_count),
        .remaining_count (remaining_count),
        .full            (full),
        .empty           (empty),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .issued_token    (issued_token),
        .exit_reject     (exit_reject)
`ifdef PARKING_FEE_EN
        ,
        .fee_out         (fee_out)
`endif
    );

    always #5 clk_1Hz = ~clk_1Hz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Maximal sequence of x^4+x^3+1 from seed 1, worked out by hand.
    int lfsr_seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

    // Reference model: slot contents plus gate-open timestamps.
    int m_slot [CAPACITY];
    int m_cyc = 0, m_pend = 0, m_x_slot = 0, m_e_opened_at = 0, m_x_opened_at = 0;
    bit m_hunt = 0, m_e_open = 0, m_x_open = 0, m_reject = 0, m_ent_prev = 0, m_ex_prev = 0;

    function automatic bit in_table(input int v);
        foreach (m_slot[i]) if (m_slot[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_count();
        int n = 0;
        foreach (m_slot[i]) if (m_slot[i] != 0) n++;
        return n;
    endfunction

    always @(posedge clk_1Hz or posedge reset) begin : model
        int t, lv, free, hit;
        bit e_fall, x_fall, lv_taken;
        if (reset) begin
            foreach (m_slot[i]) m_slot[i] = 0;
            m_cyc = 0; m_pend = 0; m_hunt = 0; m_e_open = 0; m_x_open = 0;
            m_reject = 0; m_ent_prev = 0; m_ex_prev = 0;
        end else begin
            t = m_cyc;
            lv = lfsr_seq[m_cyc % 15];
            m_cyc++;
            e_fall = m_ent_prev && !entry_sensor;
            x_fall = m_ex_prev && !exit_sensor;
            m_ent_prev = entry_sensor;
            m_ex_prev  = exit_sensor;
            lv_taken = in_table(lv);
            free = -1;
            hit  = -1;
            foreach (m_slot[i]) begin
                if (m_slot[i] == 0 && free < 0) free = i;
                if (token_in != 0 && m_slot[i] == int'(token_in) && hit < 0) hit = i;
            end
            m_reject = 0;
            if (m_x_open) begin
                if (x_fall) begin
                    m_slot[m_x_slot] = 0;
                    m_x_open = 0;
                end else if (t - m_x_opened_at == GATE_TIMEOUT) m_x_open = 0;
            end else if (exit_req) begin
                if (hit >= 0) begin
                    m_x_open = 1; m_x_slot = hit; m_x_opened_at = t;
                end else m_reject = 1;
            end
            if (m_e_open) begin
                if (e_fall && free >= 0) begin
                    m_slot[free] = m_pend;
                    m_e_open = 0; m_pend = 0;
                end else if (t - m_e_opened_at == GATE_TIMEOUT) begin
                    m_e_open = 0; m_pend = 0;
                end
            end else if (m_hunt) begin
                if (!lv_taken) begin
                    m_hunt = 0; m_e_open = 1; m_pend = lv; m_e_opened_at = t;
                end
            end else if (entry_req && (CAPACITY - free != 0) && free >= 0) begin
                m_hunt = 1;
            end
        end
    end

    always @(negedge clk_1Hz) begin : compare
        int occ;
        occ = model_count();
        check("occupied_count", int'(occupied_count), occ);
        check("remaining_count", int'(remaining_count), CAPACITY - occ);
        check("full", int'(full), int'(occ == CAPACITY));
        check("empty", int'(empty), int'(occ == 0));
        check("entry_gate_open", int'(entry_gate_open), int'(m_e_open));
        check("exit_gate_open", int'(exit_gate_open), int'(m_x_open));
        check("issued_token", int'(issued_token), m_e_open ? m_pend : 0);
        check("exit_reject", int'(exit_reject), int'(m_reject));
    end

    task automatic tick();
        @(posedge clk_1Hz);
        #2;
    endtask

    task automatic req_entry();
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
    endtask

    task automatic req_exit(input int tok);
        token_in = TOKEN_W'(tok);
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        token_in = '0;
    endtask

    task automatic wait_gate(input bit entry_side, input string name);
        int n = 0;
        while ((entry_side ? entry_gate_open : exit_gate_open) !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(name, int'(entry_side ? entry_gate_open : exit_gate_open), 1);
    endtask

    task automatic sensor_pulse(input bit entry_side);
        if (entry_side) entry_sensor = 1'b1; else exit_sensor = 1'b1;
        tick();
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int toks [CAPACITY];
        int coll, dup, unissued, newtok, n;

        repeat (3) @(posedge clk_1Hz);
        #2;
        check("reset_occupied", int'(occupied_count), 0);
        check("reset_remaining", int'(remaining_count), 9);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        check("reset_gates", int'({entry_gate_open, exit_gate_open}), 0);
        check("reset_issued", int'(issued_token), 0);
        reset = 1'b0;

        // First car: gate opens two edges after entry_req with LFSR value 4.
        tick();
        req_entry();
        tick();
        check("first_gate_open", int'(entry_gate_open), 1);
        check("first_token", int'(issued_token), 4);
        toks[0] = int'(issued_token);
        sensor_pulse(1'b1);
        check("first_occupied", int'(occupied_count), 1);
        check("first_remaining", int'(remaining_count), 8);

        // Fill the lot; the fifth car is timed to hit an LFSR collision.
        for (int c = 1; c < CAPACITY; c++) begin
            if (c == 4) begin
                n = 0;
                while (!in_table(lfsr_seq[(m_cyc + 1) % 15]) && n < 20) begin
                    tick();
                    n++;
                end
                coll = lfsr_seq[(m_cyc + 1) % 15];
                req_entry();
                tick();
                check("collision_retry_gate_closed", int'(entry_gate_open), 0);
                wait_gate(1'b1, "collision_gate_open");
                check("collision_token_distinct", int'(int'(issued_token) != coll), 1);
            end else begin
                req_entry();
                wait_gate(1'b1, "fill_gate_open");
            end
            toks[c] = int'(issued_token);
            sensor_pulse(1'b1);
        end
        check("fill_full", int'(full), 1);
        check("fill_occupied", int'(occupied_count), 9);
        dup = 0;
        for (int i = 0; i < CAPACITY; i++) begin
            if (toks[i] == 0) dup++;
            for (int j = i + 1; j < CAPACITY; j++) if (toks[i] == toks[j]) dup++;
        end
        check("tokens_unique_nonzero", dup, 0);

        req_entry();
        tick();
        tick();
        check("full_entry_ignored", int'(entry_gate_open), 0);

        // Exit the first car with its literal token.
        req_exit(4);
        check("exit_gate_open", int'(exit_gate_open), 1);
        sensor_pulse(1'b0);
        check("exit_occupied", int'(occupied_count), 8);
        check("exit_not_full", int'(full), 0);

        // Invalid exit tokens.
        req_exit(0);
        check("reject_zero", int'(exit_reject), 1);
        check("reject_zero_gate", int'(exit_gate_open), 0);
        tick();
        check("reject_one_cycle", int'(exit_reject), 0);
        unissued = 0;
        for (int v = 15; v >= 1; v--) if (!in_table(v)) unissued = v;
        req_exit(unissued);
        check("reject_unissued", int'(exit_reject), 1);
        tick();
        check("reject_count_kept", int'(occupied_count), 8);

        // Entry timeout: token discarded, count unchanged.
        req_entry();
        wait_gate(1'b1, "timeout_entry_open");
        repeat (GATE_TIMEOUT + 2) tick();
        check("entry_timeout_closed", int'(entry_gate_open), 0);
        check("entry_timeout_token", int'(issued_token), 0);
        check("entry_timeout_count", int'(occupied_count), 8);

        // Exit timeout keeps the slot; the token still works afterwards.
        req_exit(toks[1]);
        check("exit_timeout_open", int'(exit_gate_open), 1);
        repeat (GATE_TIMEOUT + 2) tick();
        check("exit_timeout_closed", int'(exit_gate_open), 0);
        check("exit_timeout_count", int'(occupied_count), 8);
        req_exit(toks[1]);
        check("exit_after_timeout_open", int'(exit_gate_open), 1);
        sensor_pulse(1'b0);
        check("exit_after_timeout_count", int'(occupied_count), 7);

        req_exit(toks[2]);
        sensor_pulse(1'b0);
        req_exit(toks[3]);
        sensor_pulse(1'b0);
        check("down_to_five", int'(occupied_count), 5);

        // Simultaneous entry and exit commit.
        req_entry();
        wait_gate(1'b1, "simul_entry_open");
        newtok = int'(issued_token);
        req_exit(toks[5]);
        check("simul_exit_open", int'(exit_gate_open), 1);
        entry_sensor = 1'b1;
        exit_sensor  = 1'b1;
        tick();
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        tick();
        check("simul_count", int'(occupied_count), 5);
        check("simul_gates", int'({entry_gate_open, exit_gate_open}), 0);
        req_exit(toks[5]);
        check("simul_old_cleared", int'(exit_reject), 1);
        tick();
        req_exit(newtok);
        check("simul_new_stored", int'(exit_gate_open), 1);
        sensor_pulse(1'b0);
        check("simul_new_exit", int'(occupied_count), 4);

`ifdef PARKING_FEE_EN
        req_entry();
        wait_gate(1'b1, "fee_entry_open");
        newtok = int'(issued_token);
        sensor_pulse(1'b1);
        repeat (20) tick();
        req_exit(newtok);
        check("fee_20_cycles", int'(fee_out), 20);
        sensor_pulse(1'b0);
`endif

        // Reset mid-operation aborts an open gate and clears the table.
        req_entry();
        wait_gate(1'b1, "reset_mid_open");
        reset = 1'b1;
        #1;
        check("mid_reset_gate", int'(entry_gate_open), 0);
        check("mid_reset_token", int'(issued_token), 0);
        check("mid_reset_count", int'(occupied_count), 0);
        tick();
        reset = 1'b0;
        tick();
        req_exit(toks[6]);
        check("mid_reset_table_cleared", int'(exit_reject), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
